key_expand_ctrl: RTL and testbench

//   Sequencer directly upstream of the 10-round AES-128 key schedule engine. Captures a cipher key,

---
 rtl/key_expand_ctrl.sv | 99 +++++++++
 tb/tb_key_expand_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expand_ctrl.sv
// Drives an AES-128 key schedule engine one round at a time and keeps round keys 0..NUM_ROUNDS.
// Read port has 1-cycle latency; a stalled engine aborts the expansion after TIMEOUT cycles in WAIT.
module key_expand_ctrl #(
  parameter int KEY_W      = 128,
  parameter int NUM_ROUNDS = 10,
  parameter int TIMEOUT    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid_in,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy_out,
  output logic             keys_ready_out,
  output logic             err_out,
  output logic             ks_start_out,
  output logic [3:0]       ks_round_out,
  output logic [KEY_W-1:0] ks_last_key_out,
  input  logic [KEY_W-1:0] ks_new_key_in,
  input  logic             ks_ready_in,
  input  logic [3:0]       rk_addr_in,
  output logic [KEY_W-1:0] rk_data_out
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q;
  logic [3:0]       round_q;
  logic [CW-1:0]    cnt_q;
  logic             err_q;
  logic [KEY_W-1:0] rk_q [0:NUM_ROUNDS];
  logic [KEY_W-1:0] rd_d;
  logic [KEY_W-1:0] rd_q;
  logic             busy;
  logic [3:0]       prev_idx;

  assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign prev_idx = round_q - 4'd1;

  assign busy_out        = busy;
  assign keys_ready_out  = (state_q == S_DONE);
  assign err_out         = err_q;
  assign ks_start_out    = (state_q == S_ISSUE);
  // Engine samples the previous key combinationally, so hold it for the whole round.
  assign ks_round_out    = busy ? round_q : 4'd0;
  assign ks_last_key_out = busy ? rk_q[prev_idx] : '0;

  assign rd_d        = (rk_addr_in <= 4'(NUM_ROUNDS)) ? rk_q[rk_addr_in] : '0;
  assign rk_data_out = rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      rd_q <= rd_d;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (key_valid_in) begin
            rk_q[0] <= key_in;
            round_q <= 4'd1;
            err_q   <= 1'b0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the final allowed cycle still counts.
          if (ks_ready_in) begin
            rk_q[round_q] <= ks_new_key_in;
            if (round_q == 4'(NUM_ROUNDS)) begin
              state_q <= S_DONE;
            end else begin
              round_q <= round_q + 4'd1;
              state_q <= S_ISSUE;
            end
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Directed bench for key_expand_ctrl with a behavioural AES-128 key schedule engine attached.
module tb_key_expand_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid_in;
  logic [127:0] key_in;
  logic         busy_out, keys_ready_out, err_out, ks_start_out;
  logic [3:0]   ks_round_out;
  logic [127:0] ks_last_key_out;
  logic [127:0] ks_new_key_in;
  logic         ks_ready_in;
  logic [3:0]   rk_addr_in;
  logic [127:0] rk_data_out;

  logic         eng_rdy, spur_rdy;
  logic [127:0] eng_key;
  assign ks_ready_in   = eng_rdy | spur_rdy;
  assign ks_new_key_in = eng_key;

  always #5 clk = ~clk;

  key_expand_ctrl #(.KEY_W(128), .NUM_ROUNDS(10), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .key_valid_in(key_valid_in), .key_in(key_in),
    .busy_out(busy_out), .keys_ready_out(keys_ready_out), .err_out(err_out),
    .ks_start_out(ks_start_out), .ks_round_out(ks_round_out), .ks_last_key_out(ks_last_key_out),
    .ks_new_key_in(ks_new_key_in), .ks_ready_in(ks_ready_in),
    .rk_addr_in(rk_addr_in), .rk_data_out(rk_data_out)
  );

  int n_vec, n_bad;
  int n_start, exp_round, stall_rnd, slow_rnd;
  logic [127:0] exp_a [0:10];
  logic [127:0] exp_b [0:10];
  logic [127:0] cur   [0:10];

  task automatic chk_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference AES-128 key schedule
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    if (x == 8'h00) r = 8'h00;
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] p, input int r);
    logic [31:0] w3, t, n0, n1, n2, n3;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xt(rc);
    w3 = p[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    t[31:24] = t[31:24] ^ rc;
    n0 = p[127:96] ^ t;
    n1 = p[95:64] ^ n0;
    n2 = p[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Engine: result 5 cycles after the start pulse, 8 in slow_rnd, never in stall_rnd.
  int           eng_r, eng_dly;
  logic [127:0] eng_lk;
  bit           eng_ab;
  initial begin
    eng_rdy = 1'b0; eng_key = '0;
    forever begin
      @(posedge clk); #1;
      eng_rdy = 1'b0;
      if (ks_start_out && !rst) begin
        eng_r  = int'(ks_round_out);
        eng_lk = ks_last_key_out;
        eng_ab = 1'b0;
        n_start++;
        chk_vec("start_round", 128'(ks_round_out), 128'(exp_round));
        chk_vec("start_last_key", eng_lk, cur[(exp_round + 10) % 11]);
        chk_vec("start_busy_ready", {busy_out, keys_ready_out}, 2'b10);
        exp_round++;
        if (eng_r != stall_rnd) begin
          eng_dly = (eng_r == slow_rnd) ? 8 : 5;
          for (int k = 1; k < eng_dly; k++) begin
            @(posedge clk); #1;
            if (rst || !busy_out) eng_ab = 1'b1;
            if (!eng_ab) begin
              if (k == 1) chk_vec("start_single_cycle", ks_start_out, 1'b0);
              chk_vec("round_stable", 128'(ks_round_out), 128'(eng_r));
              chk_vec("last_key_stable", ks_last_key_out, eng_lk);
            end
          end
          @(posedge clk); #1;
          if (!rst && busy_out && !eng_ab && eng_r >= 1 && eng_r <= 10) begin
            eng_key = cur[eng_r];
            eng_rdy = 1'b1;
          end
        end
      end
    end
  end

  task automatic rd(input int a, output logic [127:0] d);
    rk_addr_in = 4'(a);
    @(posedge clk); #1;
    d = rk_data_out;
  endtask

  task automatic run_key(input logic [127:0] key, input int poke_rnd, input int rst_rnd,
                         output int cyc);
    int rc;
    bit poked;
    rc = 0; poked = 1'b0;
    key_in = key; key_valid_in = 1'b1;
    @(posedge clk); #1;
    key_valid_in = 1'b0; cyc = 1;
    while (!keys_ready_out && !err_out && cyc < 200) begin
      if (poke_rnd != 0 && !poked && int'(ks_round_out) == poke_rnd) begin
        key_in = ~key; key_valid_in = 1'b1; poked = 1'b1;
      end
      if (rst_rnd != 0 && int'(ks_round_out) == rst_rnd) begin
        rc++;
        if (rc == 3) begin
          rst = 1'b1;
          break;
        end
      end
      @(posedge clk); #1;
      key_valid_in = 1'b0;
      cyc++;
    end
  endtask

  task automatic sweep(input string tag, input int b_upto);
    logic [127:0] d, e;
    for (int a = 0; a < 16; a++) begin
      rd(a, d);
      if (a > 10)          e = '0;
      else if (a <= b_upto) e = exp_b[a];
      else                  e = exp_a[a];
      chk_vec(tag, d, e);
    end
  endtask

  int           cyc;
  logic [127:0] d;

  initial begin
    n_vec = 0; n_bad = 0; n_start = 0; exp_round = 1; stall_rnd = 0; slow_rnd = 0;
    rst = 1'b1; key_valid_in = 1'b0; key_in = '0; rk_addr_in = '0; spur_rdy = 1'b0;
    exp_a[0] = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    exp_b[0] = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    for (int r = 1; r <= 10; r++) begin
      exp_a[r] = next_rk(exp_a[r-1], r);
      exp_b[r] = next_rk(exp_b[r-1], r);
    end
    repeat (3) @(posedge clk);
    #1;
    chk_vec("rst_flags", {busy_out, keys_ready_out, err_out, ks_start_out}, 4'b0000);
    chk_vec("rst_round", 128'(ks_round_out), '0);
    chk_vec("rst_last_key", ks_last_key_out, '0);
    chk_vec("rst_rk_data", rk_data_out, '0);
    rst = 1'b0;

    // FIPS-197 key, nominal engine
    for (int i = 0; i <= 10; i++) cur[i] = exp_a[i];
    exp_round = 1; n_start = 0;
    run_key(exp_a[0], 0, 0, cyc);
    chk_vec("fips_ready_cycle", 128'(cyc), 128'(61));
    chk_vec("fips_starts", 128'(n_start), 128'(10));
    chk_vec("fips_flags", {keys_ready_out, busy_out, err_out}, 3'b100);
    rd(1, d);  chk_vec("fips_rk1", d, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    rd(10, d); chk_vec("fips_rk10", d, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    sweep("fips_sweep", -1);

    // Engine stalls in round 3
    for (int i = 0; i <= 10; i++) cur[i] = exp_b[i];
    exp_round = 1; n_start = 0; stall_rnd = 3;
    run_key(exp_b[0], 0, 0, cyc);
    stall_rnd = 0;
    chk_vec("stall_err_cycle", 128'(cyc), 128'(22));
    chk_vec("stall_flags", {err_out, busy_out, keys_ready_out}, 3'b100);
    chk_vec("stall_round_out", 128'(ks_round_out), '0);
    chk_vec("stall_starts", 128'(n_start), 128'(3));
    sweep("stall_sweep", 2);

    // Restart clears err; round 4 result lands on the last allowed WAIT cycle
    exp_round = 1; n_start = 0; slow_rnd = 4;
    run_key(exp_b[0], 0, 0, cyc);
    slow_rnd = 0;
    chk_vec("slow_ready_cycle", 128'(cyc), 128'(64));
    chk_vec("slow_flags", {keys_ready_out, err_out}, 2'b10);
    chk_vec("slow_starts", 128'(n_start), 128'(10));
    sweep("slow_sweep", 10);

    // key_valid_in pulsed in round 5 is ignored
    for (int i = 0; i <= 10; i++) cur[i] = exp_a[i];
    exp_round = 1; n_start = 0;
    run_key(exp_a[0], 5, 0, cyc);
    chk_vec("poke_ready_cycle", 128'(cyc), 128'(61));
    chk_vec("poke_starts", 128'(n_start), 128'(10));
    sweep("poke_sweep", -1);

    // Reset in the middle of round 7
    exp_round = 1; n_start = 0; rk_addr_in = 4'd0;
    run_key(exp_a[0], 0, 7, cyc);
    @(posedge clk); #1;
    chk_vec("midrst_flags", {busy_out, keys_ready_out, err_out, ks_start_out}, 4'b0000);
    chk_vec("midrst_round", 128'(ks_round_out), '0);
    chk_vec("midrst_last_key", ks_last_key_out, '0);
    chk_vec("midrst_rk_data", rk_data_out, '0);
    chk_vec("midrst_starts", 128'(n_start), 128'(7));
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    spur_rdy = 1'b1;
    @(posedge clk); #1;
    spur_rdy = 1'b0;
    chk_vec("spur_flags", {busy_out, keys_ready_out, err_out}, 3'b000);
    rd(0, d); chk_vec("spur_rk0", d, '0);
    rd(5, d); chk_vec("midrst_rk5", d, '0);

    // Full rerun after reset
    for (int i = 0; i <= 10; i++) cur[i] = exp_b[i];
    exp_round = 1; n_start = 0;
    run_key(exp_b[0], 0, 0, cyc);
    chk_vec("rerun_ready_cycle", 128'(cyc), 128'(61));
    chk_vec("rerun_starts", 128'(n_start), 128'(10));
    sweep("rerun_sweep", 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
